soc_fpga_ram_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port code RAM (soc_fpga_ram_code* family).
- Shares the RAM between M0, the instruction-fetch side (read-only), and M1, the loader/debug side (read/write).
- Issues at most one RAM access per cycle and returns read data with fixed latency.
- Sits between the CPU fetch path and the RAM instance; the RAM itself is unchanged.

---
 rtl/soc_fpga_ram_pkg.sv | 24 ++
 rtl/soc_fpga_ram_arb_pick.sv | 59 +++++
 rtl/soc_fpga_ram_arb.sv | 93 +++++++++
 tb/tb_soc_fpga_ram_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_fpga_ram_pkg.sv
// Shared definitions for the code-RAM arbiter: requester ids, arbitration modes
// and the default geometry of the soc_fpga_ram_code* instances.
package soc_fpga_ram_pkg;

  localparam int unsigned RAM_DATAWIDTH = 32;
  localparam int unsigned RAM_ADDRWIDTH = 12;
  localparam int unsigned WAIT_W        = 8;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  // Tracks the access issued last cycle so its RAM output can be routed.
  typedef struct packed {
    logic    vld;
    req_id_e sel;
    logic    wr;
  } rsp_state_t;

endpackage

// File: rtl/soc_fpga_ram_arb_pick.sv
// Grant selection between fetch (M0) and loader (M1), with the last-grant
// and M1 starvation counters that steer conflicts.
module soc_fpga_ram_arb_pick
  import soc_fpga_ram_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic m0_valid_i,
  input  logic m1_valid_i,
  output logic gnt_m0_c_o,
  output logic gnt_m1_c_o
);

  req_id_e              last_gnt_q, last_gnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 pick_m1;

  always_comb begin
    pick_m1    = 1'b0;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = wait_cnt_q;

    // Conflict winner: alternate, or favour fetch until M1 has waited too long
    if (PRIO_MODE == PRIO_FIXED) begin
      pick_m1 = (wait_cnt_q >= WAIT_W'(MAX_WAIT));
    end else begin
      pick_m1 = (last_gnt_q == REQ_M0);
    end

    gnt_m0_c_o = rst_ni & m0_valid_i & (~m1_valid_i | ~pick_m1);
    gnt_m1_c_o = rst_ni & m1_valid_i & (~m0_valid_i |  pick_m1);

    if (gnt_m0_c_o) begin
      last_gnt_d = REQ_M0;
    end else if (gnt_m1_c_o) begin
      last_gnt_d = REQ_M1;
    end

    if (gnt_m1_c_o) begin
      wait_cnt_d = '0;
    end else if (m1_valid_i && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= REQ_M1;
      wait_cnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/soc_fpga_ram_arb.sv
// Two-requester arbiter/sequencer in front of the single-port code RAM:
// one access per cycle, read data returned the cycle after the grant.
module soc_fpga_ram_arb
  import soc_fpga_ram_pkg::*;
#(
  parameter int unsigned DATAWIDTH = RAM_DATAWIDTH,
  parameter int unsigned ADDRWIDTH = RAM_ADDRWIDTH,
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic                 PortAClk,
  input  logic                 PortAResetN,
  input  logic                 M0ReqValid,
  input  logic [ADDRWIDTH-1:0] M0ReqAddr,
  output logic                 M0ReqReady,
  output logic                 M0RspValid,
  output logic [DATAWIDTH-1:0] M0RspData,
  input  logic                 M1ReqValid,
  input  logic                 M1ReqWrite,
  input  logic [ADDRWIDTH-1:0] M1ReqAddr,
  input  logic [DATAWIDTH-1:0] M1ReqWData,
  output logic                 M1ReqReady,
  output logic                 M1RspValid,
  output logic [DATAWIDTH-1:0] M1RspData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut
);

  logic                 gnt_m0, gnt_m1;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] wdata_q;
  rsp_state_t           rsp_q, rsp_d;

  soc_fpga_ram_arb_pick #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT)
  ) u_pick (
    .clk_i      (PortAClk),
    .rst_ni     (PortAResetN),
    .m0_valid_i (M0ReqValid),
    .m1_valid_i (M1ReqValid),
    .gnt_m0_c_o (gnt_m0),
    .gnt_m1_c_o (gnt_m1)
  );

  assign M0ReqReady = gnt_m0;
  assign M1ReqReady = gnt_m1;

  // RAM mux; idle cycles replay the last granted address/data
  always_comb begin
    RamAddr        = addr_q;
    RamDataIn      = wdata_q;
    RamWriteEnable = 1'b0;
    rsp_d          = '0;

    if (gnt_m1) begin
      RamAddr        = M1ReqAddr;
      RamDataIn      = M1ReqWData;
      RamWriteEnable = M1ReqWrite;
    end else if (gnt_m0) begin
      RamAddr        = M0ReqAddr;
    end

    rsp_d.vld = gnt_m0 | gnt_m1;
    rsp_d.sel = gnt_m1 ? REQ_M1 : REQ_M0;
    rsp_d.wr  = gnt_m1 & M1ReqWrite;
  end

  always_ff @(posedge PortAClk or negedge PortAResetN) begin
    if (!PortAResetN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      if (gnt_m0 | gnt_m1) begin
        addr_q  <= RamAddr;
        wdata_q <= RamDataIn;
      end
      rsp_q <= rsp_d;
    end
  end

  // RAM output is stale after a write, so a write ack carries zero data
  always_comb begin
    M0RspValid = rsp_q.vld & (rsp_q.sel == REQ_M0);
    M1RspValid = rsp_q.vld & (rsp_q.sel == REQ_M1);
    M0RspData  = M0RspValid ? RamDataOut : '0;
    M1RspData  = (M1RspValid & ~rsp_q.wr) ? RamDataOut : '0;
  end

endmodule

// File: tb/tb_soc_fpga_ram_arb.sv
// Bench for soc_fpga_ram_arb: one round-robin and one fixed-priority instance,
// each with its own RAM model, checked against a transaction-level reference.
module tb_soc_fpga_ram_arb;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic          clk, rst_n;
  logic [1:0]    m0v, m1v, m1w, m0rdy, m1rdy, m0rv, m1rv, we;
  logic [AW-1:0] m0a [2];
  logic [AW-1:0] m1a [2];
  logic [AW-1:0] ramaddr [2];
  logic [DW-1:0] m1d [2];
  logic [DW-1:0] m0rd [2];
  logic [DW-1:0] m1rd [2];
  logic [DW-1:0] ramdin [2];
  logic [DW-1:0] ramdout [2];

  logic [DW-1:0] mem  [2][4096];
  logic [DW-1:0] refm [2][4096];

  int checks = 0;
  int errors = 0;

  // Reference state: who won last, how long M1 has waited, what is due next cycle
  bit            last_m1 [2];
  int            waitc   [2];
  int            last_g  [2];
  bit            pend    [2];
  bit            pown_m1 [2];
  logic [DW-1:0] pdata   [2];

  soc_fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .PRIO_MODE(0), .MAX_WAIT(MW)) u_rr (
    .PortAClk(clk), .PortAResetN(rst_n),
    .M0ReqValid(m0v[0]), .M0ReqAddr(m0a[0]), .M0ReqReady(m0rdy[0]),
    .M0RspValid(m0rv[0]), .M0RspData(m0rd[0]),
    .M1ReqValid(m1v[0]), .M1ReqWrite(m1w[0]), .M1ReqAddr(m1a[0]), .M1ReqWData(m1d[0]),
    .M1ReqReady(m1rdy[0]), .M1RspValid(m1rv[0]), .M1RspData(m1rd[0]),
    .RamAddr(ramaddr[0]), .RamDataIn(ramdin[0]), .RamWriteEnable(we[0]), .RamDataOut(ramdout[0])
  );

  soc_fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .PRIO_MODE(1), .MAX_WAIT(MW)) u_fp (
    .PortAClk(clk), .PortAResetN(rst_n),
    .M0ReqValid(m0v[1]), .M0ReqAddr(m0a[1]), .M0ReqReady(m0rdy[1]),
    .M0RspValid(m0rv[1]), .M0RspData(m0rd[1]),
    .M1ReqValid(m1v[1]), .M1ReqWrite(m1w[1]), .M1ReqAddr(m1a[1]), .M1ReqWData(m1d[1]),
    .M1ReqReady(m1rdy[1]), .M1RspValid(m1rv[1]), .M1RspData(m1rd[1]),
    .RamAddr(ramaddr[1]), .RamDataIn(ramdin[1]), .RamWriteEnable(we[1]), .RamDataOut(ramdout[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with registered read; output holds during writes
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we[k]) mem[k][ramaddr[k]] <= ramdin[k];
      else       ramdout[k]         <= mem[k][ramaddr[k]];
    end
  end

  // Expected grant: 0 none, 1 M0, 2 M1
  function automatic int exp_gnt(int k);
    if (!rst_n) return 0;
    if (m0v[k] && !m1v[k]) return 1;
    if (m1v[k] && !m0v[k]) return 2;
    if (!m0v[k]) return 0;
    if (k == 0) return last_m1[k] ? 1 : 2;
    return (waitc[k] >= MW) ? 2 : 1;
  endfunction

  // Advance one clock and update the reference; no checking here
  task automatic tick();
    int g;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      g = exp_gnt(k);
      last_g[k] = g;
      pend[k] = 1'b0;
      if (!rst_n) begin
        last_m1[k] = 1'b1;
        waitc[k]   = 0;
      end else begin
        if (g == 1) begin
          pend[k] = 1'b1; pown_m1[k] = 1'b0; pdata[k] = refm[k][m0a[k]]; last_m1[k] = 1'b0;
        end
        if (g == 2) begin
          pend[k] = 1'b1; pown_m1[k] = 1'b1; last_m1[k] = 1'b1; waitc[k] = 0;
          if (m1w[k]) begin
            pdata[k] = '0;
            refm[k][m1a[k]] = m1d[k];
          end else begin
            pdata[k] = refm[k][m1a[k]];
          end
        end else if (m1v[k]) begin
          waitc[k] = (waitc[k] < 255) ? waitc[k] + 1 : 255;
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      m0v[k] = 1'b0; m1v[k] = 1'b0; m1w[k] = 1'b0;
      m0a[k] = '0; m1a[k] = '0; m1d[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m0v[k] = 1'b1; m1v[k] = 1'b1; m1w[k] = 1'b1;
      m0a[k] = AW'($urandom); m1a[k] = AW'($urandom); m1d[k] = $urandom;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({m0rdy[k], m1rdy[k], we[k], m0rv[k], m1rv[k]} !== 5'b0 || m0rd[k] !== '0 ||
            m1rd[k] !== '0 || ramaddr[k] !== '0 || ramdin[k] !== '0) begin
          errors++;
          $display("FAIL reset_outputs k=%0d ctl=%b addr=%h din=%h rd0=%h rd1=%h want all zero",
                   k, {m0rdy[k], m1rdy[k], we[k], m0rv[k], m1rv[k]}, ramaddr[k], ramdin[k], m0rd[k], m1rd[k]);
        end
      end
      tick();
    end
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_m0_read();
    for (int k = 0; k < 2; k++) begin m0v[k] = 1'b1; m0a[k] = 12'h010; end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m0rdy[k] !== 1'b1 || m1rdy[k] !== 1'b0 || ramaddr[k] !== 12'h010) begin
        errors++;
        $display("FAIL m0_read_grant k=%0d rdy=%b%b addr=%h want rdy=10 addr=010", k, m0rdy[k], m1rdy[k], ramaddr[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) m0v[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m0rv[k] !== 1'b1 || m0rd[k] !== 32'hDEADBEEF || m1rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL m0_read_rsp k=%0d vld=%b data=%h m1vld=%b want vld=1 data=deadbeef m1vld=0",
                 k, m0rv[k], m0rd[k], m1rv[k]);
      end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m0rv[k] !== 1'b0 || m0rd[k] !== '0) begin
        errors++;
        $display("FAIL m0_read_single k=%0d vld=%b data=%h want 0 0", k, m0rv[k], m0rd[k]);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 2; k++) begin
      m1v[k] = 1'b1; m1w[k] = 1'b1; m1a[k] = 12'h020; m1d[k] = 32'h12345678;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m1rdy[k] !== 1'b1 || we[k] !== 1'b1 || ramaddr[k] !== 12'h020 || ramdin[k] !== 32'h12345678) begin
        errors++;
        $display("FAIL wr_issue k=%0d rdy=%b we=%b addr=%h din=%h want 1 1 020 12345678",
                 k, m1rdy[k], we[k], ramaddr[k], ramdin[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) m1w[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m1rv[k] !== 1'b1 || m1rd[k] !== '0 || we[k] !== 1'b0 || m1rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL wr_ack k=%0d vld=%b data=%h we=%b rdy=%b want 1 0 0 1", k, m1rv[k], m1rd[k], we[k], m1rdy[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) m1v[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m1rv[k] !== 1'b1 || m1rd[k] !== 32'h12345678) begin
        errors++;
        $display("FAIL raw_read k=%0d vld=%b data=%h want 1 12345678", k, m1rv[k], m1rd[k]);
      end
    end
    tick();
  endtask

  task automatic test_write_hold();
    logic [DW-1:0] d;
    d = $urandom;
    for (int k = 0; k < 2; k++) begin
      m1v[k] = 1'b1; m1w[k] = 1'b1; m1a[k] = 12'h3A5; m1d[k] = d;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (we[k] !== 1'b1 || ramaddr[k] !== 12'h3A5 || ramdin[k] !== d) begin
        errors++;
        $display("FAIL hold_issue k=%0d we=%b addr=%h din=%h want 1 3a5 %h", k, we[k], ramaddr[k], ramdin[k], d);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin m1v[k] = 1'b0; m1w[k] = 1'b0; m1a[k] = '0; m1d[k] = '0; end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (we[k] !== 1'b0 || ramaddr[k] !== 12'h3A5 || ramdin[k] !== d) begin
          errors++;
          $display("FAIL hold_idle k=%0d we=%b addr=%h din=%h want 0 3a5 %h", k, we[k], ramaddr[k], ramdin[k], d);
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    bit want_m1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m0v[k] = 1'b1; m0a[k] = 12'h010; m1v[k] = 1'b1; m1w[k] = 1'b0; m1a[k] = 12'h020;
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        want_m1 = (k == 0) ? (i % 2 == 1) : (i == 8 || i == 17);
        checks++;
        if (m0rdy[k] !== !want_m1 || m1rdy[k] !== want_m1) begin
          errors++;
          $display("FAIL conflict k=%0d cyc=%0d rdy=%b%b want %b%b", k, i, m0rdy[k], m1rdy[k], !want_m1, want_m1);
        end
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 2; k++) begin m0v[k] = 1'b1; m0a[k] = 12'h010; end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m0rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL mid_grant k=%0d rdy=%b want 1", k, m0rdy[k]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({m0rdy[k], m1rdy[k], we[k], m0rv[k], m1rv[k]} !== 5'b0 || m0rd[k] !== '0 ||
          m1rd[k] !== '0 || ramaddr[k] !== '0 || ramdin[k] !== '0) begin
        errors++;
        $display("FAIL mid_reset_outputs k=%0d ctl=%b addr=%h din=%h want all zero",
                 k, {m0rdy[k], m1rdy[k], we[k], m0rv[k], m1rv[k]}, ramaddr[k], ramdin[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    set_idle();
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (m0rv[k] !== 1'b0 || m1rv[k] !== 1'b0) begin
          errors++;
          $display("FAIL mid_dropped k=%0d vld=%b%b want 00", k, m0rv[k], m1rv[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int            eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] e0, e1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eg = exp_gnt(k);
        checks++;
        if (m0rdy[k] !== (eg == 1) || m1rdy[k] !== (eg == 2) || we[k] !== (eg == 2 && m1w[k])) begin
          errors++;
          $display("FAIL rnd_grant k=%0d cyc=%0d rdy=%b%b we=%b want gnt=%0d wr=%b", k, c, m0rdy[k], m1rdy[k], we[k], eg, m1w[k]);
        end
        if (eg != 0) begin
          ea = (eg == 2) ? m1a[k] : m0a[k];
          checks++;
          if (ramaddr[k] !== ea) begin
            errors++;
            $display("FAIL rnd_addr k=%0d cyc=%0d addr=%h want %h", k, c, ramaddr[k], ea);
          end
        end
        e0 = (pend[k] && !pown_m1[k]) ? pdata[k] : '0;
        e1 = (pend[k] &&  pown_m1[k]) ? pdata[k] : '0;
        checks++;
        if (m0rv[k] !== (pend[k] && !pown_m1[k]) || m1rv[k] !== (pend[k] && pown_m1[k]) ||
            m0rd[k] !== e0 || m1rd[k] !== e1) begin
          errors++;
          $display("FAIL rnd_rsp k=%0d cyc=%0d vld=%b%b d0=%h d1=%h want vld=%b%b d0=%h d1=%h", k, c,
                   m0rv[k], m1rv[k], m0rd[k], m1rd[k], pend[k] && !pown_m1[k], pend[k] && pown_m1[k], e0, e1);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!m0v[k] || last_g[k] == 1) begin
          m0v[k] = ($urandom_range(0, 3) != 0);
          m0a[k] = AW'($urandom_range(0, 15));
        end
        if (!m1v[k] || last_g[k] == 2) begin
          m1v[k] = ($urandom_range(0, 2) != 0);
          m1w[k] = 1'($urandom_range(0, 1));
          m1a[k] = AW'($urandom_range(0, 15));
          m1d[k] = $urandom;
        end
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4096; a++) begin
        mem[k][a]  <= 32'hA5A5_0000 | 32'(a);
        refm[k][a]  = 32'hA5A5_0000 | 32'(a);
      end
      mem[k][16]  <= 32'hDEADBEEF;
      refm[k][16]  = 32'hDEADBEEF;
      last_m1[k] = 1'b1; waitc[k] = 0; last_g[k] = 0; pend[k] = 1'b0; pown_m1[k] = 1'b0; pdata[k] = '0;
    end
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_m0_read();
    test_write_read();
    test_write_hold();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
